// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_TICK_DIV        = 500000;
  localparam int DEF_HB_TICKS        = 50;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability filter and one-cycle press pulse for an active-low key.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, stable_q, press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mismatch, accept;

  assign mismatch = (sync2_q != stable_q);
  // Accept on the edge that completes DEBOUNCE_CYCLES consecutive mismatched cycles.
  assign accept   = mismatch && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      if (accept) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else if (mismatch) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      press_q <= accept && stable_q && !sync2_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: key filtering, IDLE/RUN/PAUSE control, 10 ms tick divider,
// display freeze toggle, datapath clear and status LEDs.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int HB_TICKS        = DEF_HB_TICKS
) (
  input  logic CLOCK_50,
  input  logic key_reset,
  input  logic key_start_pause,
  input  logic key_display_stop,
  output logic counter_work,
  output logic tick_10ms,
  output logic display_work,
  output logic clr_counters,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3
);

  localparam int               DIV_W    = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam int               HB_W     = cnt_width(HB_TICKS);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_TICKS - 1);

  logic press_sp, press_dp;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sp (
    .clk_i  (CLOCK_50),
    .rst_ni (key_reset),
    .key_i  (key_start_pause),
    .press_o(press_sp)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dp (
    .clk_i  (CLOCK_50),
    .rst_ni (key_reset),
    .key_i  (key_display_stop),
    .press_o(press_dp)
  );

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic             tick_q, tick_d;
  logic             disp_q, disp_d;
  logic             led3_q, led3_d;
  logic             cw_q, clr_q, led0_q, led1_q, led2_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hb_d    = hb_q;
    tick_d  = 1'b0;
    led3_d  = led3_q;
    disp_d  = disp_q ^ press_dp;

    case (state_q)
      ST_IDLE:  if (press_sp) state_d = ST_RUN;
      ST_RUN:   if (press_sp) state_d = ST_PAUSE;
      ST_PAUSE: if (press_sp) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    // PAUSE keeps the sub-tick fraction so a resume finishes the interrupted 10 ms.
    if (state_q == ST_RUN) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
        if (hb_q == HB_LAST) begin
          hb_d   = '0;
          led3_d = ~led3_q;
        end else begin
          hb_d = hb_q + 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end else if (state_q != ST_PAUSE) begin
      div_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!key_reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      hb_q    <= '0;
      tick_q  <= 1'b0;
      disp_q  <= 1'b1;
      cw_q    <= 1'b0;
      clr_q   <= 1'b1;
      led0_q  <= 1'b0;
      led1_q  <= 1'b0;
      led2_q  <= 1'b0;
      led3_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hb_q    <= hb_d;
      tick_q  <= tick_d;
      disp_q  <= disp_d;
      cw_q    <= (state_d == ST_RUN);
      clr_q   <= 1'b0;
      led0_q  <= (state_d == ST_RUN);
      led1_q  <= ~disp_d;
      led2_q  <= (state_d == ST_PAUSE);
      led3_q  <= led3_d;
    end
  end

  assign counter_work = cw_q;
  assign tick_10ms    = tick_q;
  assign display_work = disp_q;
  assign clr_counters = clr_q;
  assign led0         = led0_q;
  assign led1         = led1_q;
  assign led2         = led2_q;
  assign led3         = led3_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and random keys vs a reference model.
module tb_stopwatch_ctrl;

  localparam int D = 4;
  localparam int T = 5;
  localparam int H = 2;

  logic CLOCK_50 = 1'b0;
  logic key_reset = 1'b0;
  logic key_start_pause = 1'b1;
  logic key_display_stop = 1'b1;
  logic counter_work, tick_10ms, display_work, clr_counters;
  logic led0, led1, led2, led3;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T), .HB_TICKS(H)) dut (
    .CLOCK_50        (CLOCK_50),
    .key_reset       (key_reset),
    .key_start_pause (key_start_pause),
    .key_display_stop(key_display_stop),
    .counter_work    (counter_work),
    .tick_10ms       (tick_10ms),
    .display_work    (display_work),
    .clr_counters    (clr_counters),
    .led0            (led0),
    .led1            (led1),
    .led2            (led2),
    .led3            (led3)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keys are judged by a sliding window of raw samples,
  // timing by counting RUN cycles and ticks since the last clear.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int         m_state = M_IDLE;
  int         m_run_cycles = 0;
  int         m_ticks = 0;
  bit         m_disp = 1'b1, m_clr = 1'b1, m_tick = 1'b0;
  bit         m_press_sp = 1'b0, m_press_dp = 1'b0;
  bit         m_stable_sp = 1'b1, m_stable_dp = 1'b1;
  logic [D:0] m_hist_sp = '1, m_hist_dp = '1;

  // A level is accepted once the D synchronised samples before the current edge all disagree with it.
  task automatic deb(input bit raw, inout logic [D:0] h, inout bit stable, output bit press);
    press = 1'b0;
    if (h[D:1] == {D{~stable}}) begin
      stable = ~stable;
      press  = ~stable;
    end
    h = {h[D-1:0], raw};
  endtask

  task automatic model_edge(input bit r, input bit sp, input bit dp);
    if (!r) begin
      m_state = M_IDLE; m_disp = 1'b1; m_clr = 1'b1; m_tick = 1'b0;
      m_run_cycles = 0; m_ticks = 0;
      m_stable_sp = 1'b1; m_stable_dp = 1'b1;
      m_hist_sp = '1; m_hist_dp = '1;
      m_press_sp = 1'b0; m_press_dp = 1'b0;
    end else begin
      m_clr  = 1'b0;
      m_tick = 1'b0;
      if (m_state == M_RUN) begin
        m_run_cycles++;
        if (m_run_cycles % T == 0) begin
          m_tick = 1'b1;
          m_ticks++;
        end
      end else if (m_state == M_IDLE) begin
        m_run_cycles = 0;
      end
      if (m_press_sp) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      if (m_press_dp) m_disp = ~m_disp;
      deb(sp, m_hist_sp, m_stable_sp, m_press_sp);
      deb(dp, m_hist_dp, m_stable_dp, m_press_dp);
    end
  endtask

  task automatic compare_model();
    chk("model counter_work", counter_work, 32'(m_state == M_RUN));
    chk("model tick_10ms", tick_10ms, 32'(m_tick));
    chk("model display_work", display_work, 32'(m_disp));
    chk("model clr_counters", clr_counters, 32'(m_clr));
    chk("model leds", {led3, led2, led1, led0},
        {28'd0, 1'((m_ticks / H) % 2), 1'(m_state == M_PAUSE), ~m_disp, 1'(m_state == M_RUN)});
  endtask

  // Drive at the falling edge, clock, then compare half a period later.
  task automatic step(input bit r, input bit sp, input bit dp);
    key_reset = r; key_start_pause = sp; key_display_stop = dp;
    @(posedge CLOCK_50);
    model_edge(r, sp, dp);
    @(negedge CLOCK_50);
    compare_model();
  endtask

  task automatic hold(input int n, input bit sp, input bit dp);
    for (int i = 0; i < n; i++) step(1'b1, sp, dp);
  endtask

  typedef struct {
    bit       rst_n;
    bit       sp;
    bit       dp;
    bit       cw;
    bit       tick;
    bit       dw;
    bit       clr;
    bit [3:0] leds;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit r, input bit sp, input bit dp, input bit cw, input bit tick,
                         input bit dw, input bit clr, input bit [3:0] leds);
    vec_t v;
    v.rst_n = r; v.sp = sp; v.dp = dp; v.cw = cw; v.tick = tick; v.dw = dw; v.clr = clr; v.leds = leds;
    vecs.push_back(v);
  endtask

  int tcount;
  int sp_len, dp_len;
  bit sp_lvl, dp_lvl;

  initial begin
    // Reset for 3 cycles, then start key held for 10 edges (press at edge 6, RUN from edge 7).
    for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    for (int e = 1; e <= 18; e++) begin
      add_vec(1'b1, (e > 10), 1'b1, (e >= 7), (e == 12 || e == 17), 1'b1, 1'b0,
              {(e >= 17), 1'b0, 1'b0, (e >= 7)});
    end

    @(negedge CLOCK_50);
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].sp, vecs[i].dp);
      chk("vec counter_work", counter_work, 32'(vecs[i].cw));
      chk("vec tick_10ms", tick_10ms, 32'(vecs[i].tick));
      chk("vec display_work", display_work, 32'(vecs[i].dw));
      chk("vec clr_counters", clr_counters, 32'(vecs[i].clr));
      chk("vec leds", {led3, led2, led1, led0}, 32'(vecs[i].leds));
    end

    // Bounce: 3 low samples are rejected, 4 are accepted.
    hold(3, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b1);
    chk("bounce3 still running", counter_work, 32'd1);
    chk("bounce3 not paused", led2, 32'd0);
    hold(4, 1'b0, 1'b1);
    hold(2, 1'b1, 1'b1);
    chk("bounce4 before effect", counter_work, 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("bounce4 paused cw", counter_work, 32'd0);
    chk("bounce4 paused led2", led2, 32'd1);

    // Pause with divider at 3, then resume: first tick two edges after RUN.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    hold(2, 1'b1, 1'b1);
    hold(4, 1'b0, 1'b1);
    hold(9, 1'b1, 1'b1);
    hold(4, 1'b0, 1'b1);
    hold(3, 1'b1, 1'b1);
    chk("pause cw", counter_work, 32'd0);
    chk("pause led2", led2, 32'd1);
    tcount = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1);
      tcount += int'(tick_10ms);
    end
    chk("pause no ticks", tcount, 32'd0);
    hold(4, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("resume not yet", counter_work, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("resume cw", counter_work, 32'd1);
    chk("resume tick at +0", tick_10ms, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("resume tick at +1", tick_10ms, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("resume tick at +2", tick_10ms, 32'd1);

    // Display freeze in RUN: ticks keep coming.
    hold(4, 1'b1, 1'b0);
    hold(2, 1'b1, 1'b1);
    chk("freeze not yet", display_work, 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("freeze display_work", display_work, 32'd0);
    chk("freeze led1", led1, 32'd1);
    tcount = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b1);
      tcount += int'(tick_10ms);
    end
    chk("freeze ticks continue", tcount, 32'd2);
    hold(4, 1'b1, 1'b0);
    hold(3, 1'b1, 1'b1);
    chk("unfreeze display_work", display_work, 32'd1);
    chk("unfreeze led1", led1, 32'd0);

    // Reset mid-RUN with both keys held low, then release reset with keys still low.
    step(1'b0, 1'b0, 1'b0);
    chk("midreset cw", counter_work, 32'd0);
    chk("midreset clr", clr_counters, 32'd1);
    chk("midreset tick", tick_10ms, 32'd0);
    chk("midreset dw", display_work, 32'd1);
    chk("midreset leds", {led3, led2, led1, led0}, 32'd0);
    hold(6, 1'b0, 1'b0);
    chk("post-reset no early press cw", counter_work, 32'd0);
    chk("post-reset no early press dw", display_work, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("post-reset run", counter_work, 32'd1);
    chk("post-reset freeze", display_work, 32'd0);
    tcount = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      tcount += int'(tick_10ms);
    end
    chk("post-reset divider cleared", tcount, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("post-reset first tick", tick_10ms, 32'd1);

    // Random key activity with occasional resets, checked every cycle against the model.
    sp_lvl = 1'b1; dp_lvl = 1'b1; sp_len = 0; dp_len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (sp_len == 0) begin
        sp_lvl = ~sp_lvl;
        sp_len = $urandom_range(1, 9);
      end
      if (dp_len == 0) begin
        dp_lvl = ~dp_lvl;
        dp_len = $urandom_range(1, 12);
      end
      sp_len--;
      dp_len--;
      step(($urandom_range(0, 199) != 0), sp_lvl, dp_lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
